decryption_demux: RTL

DECRYPTION_DEMUX -- requirements
Module: decryption_demux

---
 rtl/decryption_demux_pkg.sv | 14 +
 rtl/decryption_demux_if.sv | 29 ++
 rtl/decryption_demux_word_serializer.sv | 37 +++
 rtl/decryption_demux.sv | 63 ++++++
 4 files changed

// File: rtl/decryption_demux_pkg.sv
// decryption_demux_pkg: channel encodings, FSM state type and byte-order constant shared by the demux files
package decryption_demux_pkg;
  typedef enum logic [1:0] {
    CH_CAESAR  = 2'd0,
    CH_SCYTALE = 2'd1,
    CH_ZIGZAG  = 2'd2,
    CH_INVALID = 2'd3
  } chan_e;
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
  localparam logic [1:0] FIRST_BYTE = 2'd3;
endpackage

// File: rtl/decryption_demux_if.sv
// decryption_demux_if: word handshake plus per-channel busy/data/valid and error strobe
// master drives select/data_i/valid_i/busy*_i; slave (the demux) drives ready_o/data*_o/valid*_o/err_o
interface decryption_demux_if #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
) ();
  logic [1:0]            select;
  logic [MST_DWIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  busy0_i;
  logic                  busy1_i;
  logic                  busy2_i;
  logic [SYS_DWIDTH-1:0] data0_o;
  logic [SYS_DWIDTH-1:0] data1_o;
  logic [SYS_DWIDTH-1:0] data2_o;
  logic                  valid0_o;
  logic                  valid1_o;
  logic                  valid2_o;
  logic                  err_o;
  modport master (
    output select, data_i, valid_i, busy0_i, busy1_i, busy2_i,
    input  ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o, err_o
  );
  modport slave (
    input  select, data_i, valid_i, busy0_i, busy1_i, busy2_i,
    output ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o, err_o
  );
endinterface

// File: rtl/decryption_demux_word_serializer.sv
// word_serializer: holds the accepted word and its channel, walks a byte counter from 3 down to 0
// Ports: clk, rst_n (sync, active-low); load/word_i/chan_i capture a word; advance steps the counter;
// byte_o is the current byte (counter 3 = MSB byte), chan_o the latched channel, last_o flags byte 0.
module word_serializer
  import decryption_demux_pkg::*;
#(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [MST_DWIDTH-1:0] word_i,
  input  chan_e                 chan_i,
  input  logic                  advance,
  output logic [SYS_DWIDTH-1:0] byte_o,
  output chan_e                 chan_o,
  output logic                  last_o
);
  logic [3:0][SYS_DWIDTH-1:0] word_q;
  logic [1:0]                 cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt    <= 2'd0;
      chan_o <= CH_CAESAR;
    end else if (load) begin
      word_q <= word_i;
      cnt    <= FIRST_BYTE;
      chan_o <= chan_i;
    end else if (advance && !last_o) begin
      cnt <= cnt - 2'd1;
    end
  end
  assign byte_o = word_q[cnt];
  assign last_o = cnt == 2'd0;
endmodule

// File: rtl/decryption_demux.sv
// decryption_demux: accepts a word, then streams its bytes MSB first to the selected decryption engine
// Ports: clk, rst_n (sync, active-low); bus (slave modport) carries select/data_i/valid_i/ready_o,
// busy0_i..busy2_i back-pressure, data0_o..data2_o with valid0_o..valid2_o, and err_o for select=3.
module decryption_demux
  import decryption_demux_pkg::*;
#(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  decryption_demux_if.slave bus
);
  state_e                state, state_nxt;
  chan_e                 chan, sel_in;
  logic [SYS_DWIDTH-1:0] byte_cur;
  logic                  accept, bad, load, last, busy_cur, emit;
  assign sel_in = chan_e'(bus.select);
  assign accept = state == IDLE && bus.valid_i && bus.ready_o;
  assign bad    = accept && sel_in == CH_INVALID;
  assign load   = accept && !bad;
  // only the latched channel's engine can stall the stream
  assign busy_cur = chan == CH_CAESAR  ? bus.busy0_i :
                    chan == CH_SCYTALE ? bus.busy1_i :
                    chan == CH_ZIGZAG  ? bus.busy2_i : 1'b1;
  // the byte shown this cycle is consumed at the coming edge
  assign emit = state == SEND && !busy_cur;
  always_comb begin
    state_nxt = state;
    state_nxt = load ? SEND : (emit && last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.ready_o <= 1'b1;
      bus.err_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.ready_o <= state_nxt == IDLE;
      bus.err_o   <= bad;
    end
  end
  word_serializer #(
    .MST_DWIDTH(MST_DWIDTH),
    .SYS_DWIDTH(SYS_DWIDTH)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .word_i (bus.data_i),
    .chan_i (sel_in),
    .advance(emit),
    .byte_o (byte_cur),
    .chan_o (chan),
    .last_o (last)
  );
  assign bus.valid0_o = emit && chan == CH_CAESAR;
  assign bus.valid1_o = emit && chan == CH_SCYTALE;
  assign bus.valid2_o = emit && chan == CH_ZIGZAG;
  assign bus.data0_o  = bus.valid0_o ? byte_cur : '0;
  assign bus.data1_o  = bus.valid1_o ? byte_cur : '0;
  assign bus.data2_o  = bus.valid2_o ? byte_cur : '0;
endmodule
